cic_interpolator: RTL

CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

---
 rtl/cic_interpolator.sv | 87 ++++++++
 1 files changed

// File: rtl/cic_interpolator.sv
// CIC interpolator: ORDER low-rate combs, zero-stuffing by INTERP_RATIO, ORDER pipelined
// integrators. The output is the top OUTPUT_WIDTH bits of the last integrator.
module cic_interpolator #(
  parameter int ORDER        = 3,
  parameter int INTERP_RATIO = 64,
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [INPUT_WIDTH-1:0]  din,
  input  logic                           din_valid,
  output logic                           din_ready,
  output logic signed [OUTPUT_WIDTH-1:0] dout,
  output logic                           dout_valid,
  output logic                           underrun
);
  localparam int PW = $clog2(INTERP_RATIO);
  localparam int W  = INPUT_WIDTH + (ORDER - 1) * PW;

  logic [PW-1:0]       r_phase;
  logic                w_phase0;
  logic signed [W-1:0] w_sample;
  logic signed [W-1:0] w_stuff;
  logic signed [W-1:0] r_cout;
  logic [ORDER:0]      r_vld_pipe;
  logic                r_underrun;

  assign w_phase0  = (r_phase == '0);
  assign din_ready = w_phase0;
  // A missing sample in its slot is replaced by zero so the filter keeps its cadence.
  assign w_sample  = din_valid ? W'(din) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= '0;
      r_vld_pipe <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_phase    <= r_phase + 1'b1;
      r_vld_pipe <= {r_vld_pipe[ORDER-1:0], 1'b1};
      if (w_phase0 && !din_valid) r_underrun <= 1'b1;
    end
  end

  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    logic signed [W-1:0] w_x;
    logic signed [W-1:0] w_y;
    logic signed [W-1:0] r_dly;
    if (k == 0) begin : g_first
      assign w_x = w_sample;
    end else begin : g_next
      assign w_x = g_comb[k-1].w_y;
    end
    assign w_y = w_x - r_dly;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_dly <= '0;
      else if (w_phase0) r_dly <= w_x;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_cout <= '0;
    else if (w_phase0) r_cout <= g_comb[ORDER-1].w_y;
  end

  // The comb result feeds the integrators only in the cycle right after the slot edge.
  assign w_stuff = (r_phase == PW'(1)) ? r_cout : '0;

  for (genvar k = 0; k < ORDER; k++) begin : g_int
    logic signed [W-1:0] w_add;
    logic signed [W-1:0] r_acc;
    if (k == 0) begin : g_first
      assign w_add = w_stuff;
    end else begin : g_next
      assign w_add = g_int[k-1].r_acc;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_acc <= '0;
      else        r_acc <= r_acc + w_add;
    end
  end

  assign dout       = g_int[ORDER-1].r_acc[W-1 -: OUTPUT_WIDTH];
  assign dout_valid = r_vld_pipe[ORDER];
  assign underrun   = r_underrun;
endmodule
